smem_result_writer: RTL

Downstream sink for the SMEM result buffer. Grants the buffer's output permit, captures its 512-bit result lines (read headers and MEM pairs) into a small FIFO, and issues them as line-granular host write requests to consecutive addresses from a programmed base. It throttles the buffer through `stall` so that no line is lost under host back-pressure, and reports completion once the buffer signals finish and the FIFO has drained.

---
 rtl/smem_pkg.sv | 20 ++
 rtl/result_line_fifo.sv | 74 +++++++
 rtl/smem_result_writer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/smem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smem_pkg
// Description : Shared types and constants for the SMEM result path.
// Revision    : 1.0 - initial release
// ============================================================================
package smem_pkg;

    localparam int LINE_WIDTH = 512;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_REQ = 3'd1,
        ST_STREAM   = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } writer_state_t;

endpackage
`default_nettype wire

// File: rtl/result_line_fifo.sv
`default_nettype none
// ============================================================================
// Module      : result_line_fifo
// Description : Synchronous line FIFO with an occupancy count and registered head.
// Revision    : 1.0 - initial release
// ============================================================================
module result_line_fifo
    import smem_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic [LINE_WIDTH-1:0]       push_data,
    input  logic                        pop,
    output logic [LINE_WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_ONE   = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [LINE_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;
    logic [LINE_WIDTH-1:0] r_head;
    logic [c_PTR_W-1:0]    w_rd_next;

    assign w_rd_next = r_rd_ptr + 1'b1;
    assign head      = r_head;
    assign count     = r_count;
    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (push && !pop) begin
                r_count <= r_count + 1'b1;
            end else if (!push && pop) begin
                r_count <= r_count - 1'b1;
            end
            // The head bypasses storage when the incoming line becomes the oldest entry.
            if (push && ((r_count == '0) || ((r_count == c_ONE) && pop))) begin
                r_head <= push_data;
            end else if (pop && (r_count > c_ONE)) begin
                r_head <= r_mem[w_rd_next];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/smem_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : smem_result_writer
// Description : Captures SMEM result lines and writes them to consecutive host
//               line addresses, throttling upstream to avoid loss.
// Revision    : 1.0 - initial release
// ============================================================================
module smem_result_writer
    import smem_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic                     output_request,
    output logic                     output_permit,
    input  logic [LINE_WIDTH-1:0]    output_data,
    input  logic                     output_valid,
    input  logic                     output_finish,
    output logic                     stall,
    output logic                     wr_req,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [LINE_WIDTH-1:0]    wr_data,
    input  logic                     wr_ack,
    output logic                     done,
    output logic [31:0]              lines_written,
    output logic                     overflow
);

    localparam int                 c_CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_STALL_TH = c_CNT_W'(FIFO_DEPTH - AF_MARGIN);

    writer_state_t          r_state;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [31:0]            r_lines_written;
    logic                   r_permit;
    logic                   r_stall;
    logic                   r_done;
    logic                   r_overflow;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [c_CNT_W-1:0]     w_count;
    logic [c_CNT_W-1:0]     w_next_count;
    logic [LINE_WIDTH-1:0]  w_head;

    assign w_pop  = !w_empty && wr_ack;
    // A full FIFO still takes a line when the head leaves in the same cycle.
    assign w_push = (r_state == ST_STREAM) && output_valid && (!w_full || w_pop);
    assign w_drop = output_valid && !w_push;

    always_comb begin
        w_next_count = w_count;
        if (w_push && !w_pop) begin
            w_next_count = w_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_next_count = w_count - 1'b1;
        end
    end

    result_line_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (output_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign output_permit = r_permit;
    assign stall         = r_stall;
    assign done          = r_done;
    assign overflow      = r_overflow;
    assign lines_written = r_lines_written;
    assign wr_req        = !w_empty;
    assign wr_data       = w_head;
    assign wr_addr       = r_base + ADDR_WIDTH'(r_lines_written);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_base          <= '0;
            r_lines_written <= '0;
            r_permit        <= 1'b0;
            r_stall         <= 1'b0;
            r_done          <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_stall <= (w_next_count >= c_STALL_TH);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop && (r_lines_written != '1)) begin
                r_lines_written <= r_lines_written + 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_base          <= base_addr;
                        r_lines_written <= '0;
                        r_done          <= 1'b0;
                        r_state         <= ST_WAIT_REQ;
                    end
                end
                ST_WAIT_REQ: begin
                    if (output_request) begin
                        r_permit <= 1'b1;
                        r_state  <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (output_finish) begin
                        r_permit <= 1'b0;
                        r_state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
